// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one memory port between the I-cache and D-cache through an IDLE/SERVE/RESP FSM.
// Define PMEM_ARBITER_ROUND_ROBIN_EN to alternate grants on contention; otherwise D always wins.
module pmem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);
    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
    state_t                r_state, w_next;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [LINE_WIDTH-1:0] r_wdata, r_line;
    logic                  w_d_req, w_d_wins, w_grant_i, w_grant_d;
    assign w_d_req = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARBITER_ROUND_ROBIN_EN
    logic r_last_d;
    assign w_d_wins = ~r_last_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_last_d <= 1'b0;
        else if (w_grant_i | w_grant_d) r_last_d <= w_grant_d;
`else
    assign w_d_wins = 1'b1;
`endif
    assign w_grant_d = (r_state == IDLE) & w_d_req & (~i_pmem_read | w_d_wins);
    assign w_grant_i = (r_state == IDLE) & i_pmem_read & ~w_grant_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant_d ? SERVE_D : w_grant_i ? SERVE_I : IDLE;
            SERVE_I: w_next = pmem_resp ? RESP_I : SERVE_I;
            SERVE_D: w_next = pmem_resp ? RESP_D : SERVE_D;
            default: w_next = IDLE;
        endcase
    end
    // A D request with both strobes high is issued as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_line    <= '0;
        end else begin
            if (w_grant_i | w_grant_d) begin
                r_write   <= w_grant_d & d_pmem_write;
                r_address <= w_grant_d ? d_pmem_address : i_pmem_address;
            end
            if (w_grant_d) r_wdata <= d_pmem_wdata;
            if (((r_state == SERVE_I) | (r_state == SERVE_D)) & pmem_resp) r_line <= pmem_rdata;
        end
    end
    always_comb begin
        pmem_read    = (r_state == SERVE_I) | ((r_state == SERVE_D) & ~r_write);
        pmem_write   = (r_state == SERVE_D) & r_write;
        pmem_address = r_address;
        pmem_wdata   = r_wdata;
        i_pmem_resp  = r_state == RESP_I;
        d_pmem_resp  = r_state == RESP_D;
        i_pmem_rdata = r_line;
        d_pmem_rdata = r_line;
    end
endmodule
